// File: rtl/lcd_write_arbiter_if.sv
// Bus bundle between the two byte producers, the arbiter and the LCD
// character port. The arbiter takes the slave side; the environment
// (producers plus Module_LCD_Control) takes the master side.
interface lcd_write_arbiter_if;
  logic       iReq0_Valid;
  logic [7:0] iReq0_Data;
  logic       oReq0_Full;
  logic       iReq1_Valid;
  logic [7:0] iReq1_Data;
  logic       oReq1_Full;
  logic       iLCD_Ready;
  logic [7:0] oLCD_Data;
  logic       oLCD_Data_Ready;
  logic       oGrant;
  logic       oBusy;
  logic [1:0] oOverflow;

  modport slave (
    input  iReq0_Valid, iReq0_Data, iReq1_Valid, iReq1_Data, iLCD_Ready,
    output oReq0_Full, oReq1_Full, oLCD_Data, oLCD_Data_Ready, oGrant, oBusy, oOverflow
  );

  modport master (
    output iReq0_Valid, iReq0_Data, iReq1_Valid, iReq1_Data, iLCD_Ready,
    input  oReq0_Full, oReq1_Full, oLCD_Data, oLCD_Data_Ready, oGrant, oBusy, oOverflow
  );
endinterface

// File: rtl/lcd_write_arbiter.sv
// Two-requester byte arbiter in front of Module_LCD_Control. Each requester
// owns a small FIFO; a round-robin pick feeds a strobe/ack handshake FSM that
// re-strobes the same byte if the LCD never drops oReadyForData.
module lcd_write_arbiter #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  lcd_write_arbiter_if.slave    bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  logic [1:0]       push_v, push_ok, pop_v, full, nempty;
  logic [1:0][7:0]  push_d;
  logic [7:0]       mem_q [2][FIFO_DEPTH];
  logic [AW-1:0]    wr_q  [2];
  logic [AW-1:0]    rd_q  [2];
  logic [AW:0]      cnt_q [2];
  logic [1:0]       ovf_q;

  state_t           state_q;
  logic [7:0]       data_q;
  logic             stb_q, grant_q, busy_q, rr_q;
  logic [TW-1:0]    tmo_q;
  logic             win, take;

  assign push_v = {bus.iReq1_Valid, bus.iReq0_Valid};
  assign push_d = {bus.iReq1_Data,  bus.iReq0_Data};

  // Flags come from the registered counts only, so a pop in the same cycle
  // never makes room for a push that arrives against a full FIFO.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      full[n]    = (cnt_q[n] == DEPTH_C);
      nempty[n]  = (cnt_q[n] != '0);
      push_ok[n] = push_v[n] && !full[n];
    end
  end

  // Winner: the lone non-empty FIFO, or the one not served last when both wait.
  always_comb begin
    win = nempty[1];
    if (nempty[0] && nempty[1]) win = ~rr_q;
  end

  assign take  = (state_q == IDLE) && bus.iLCD_Ready && (|nempty);
  assign pop_v = take ? (win ? 2'b10 : 2'b01) : 2'b00;

  // FIFO storage array; contents need no reset since counts gate every read.
  always_ff @(posedge Clock) begin
    for (int n = 0; n < 2; n++)
      if (push_ok[n]) mem_q[n][wr_q[n]] <= push_d[n];
  end

  // FIFO pointers, occupancy counts and sticky overflow flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int n = 0; n < 2; n++) begin
        wr_q[n]  <= '0;
        rd_q[n]  <= '0;
        cnt_q[n] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push_ok[n]) wr_q[n] <= wr_q[n] + PTR_ONE;
        if (pop_v[n])   rd_q[n] <= rd_q[n] + PTR_ONE;
        if (push_ok[n] && !pop_v[n])      cnt_q[n] <= cnt_q[n] + CNT_ONE;
        else if (!push_ok[n] && pop_v[n]) cnt_q[n] <= cnt_q[n] - CNT_ONE;
        if (push_v[n] && full[n]) ovf_q[n] <= 1'b1;
      end
    end
  end

  // Handshake FSM with registered LCD outputs. The strobe is raised on the
  // edge entering ISSUE so it is high exactly while the FSM sits in ISSUE.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      stb_q   <= 1'b0;
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= '0;
      rr_q    <= 1'b1;   // "last served = req1" so req0 wins the first tie
    end else begin
      stb_q <= 1'b0;
      case (state_q)
        IDLE: if (take) begin
          data_q  <= mem_q[win][rd_q[win]];
          grant_q <= win;
          stb_q   <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          tmo_q   <= '0;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!bus.iLCD_Ready) begin
            state_q <= WAIT_DONE;
          end else if (tmo_q == TMO_LAST) begin
            stb_q   <= 1'b1;   // LCD missed it: strobe the same byte again
            state_q <= ISSUE;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
          end
        end
        WAIT_DONE: if (bus.iLCD_Ready) begin
          rr_q    <= grant_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oReq0_Full      = full[0];
  assign bus.oReq1_Full      = full[1];
  assign bus.oLCD_Data       = data_q;
  assign bus.oLCD_Data_Ready = stb_q;
  assign bus.oGrant          = grant_q;
  assign bus.oBusy           = busy_q;
  assign bus.oOverflow       = ovf_q;
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: a timestamp-based transaction model
// predicts every output each cycle, an LCD responder acks strobes, and the
// directed tests pin key timings and byte orders with literal values.
module tb_lcd_write_arbiter;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  lcd_write_arbiter_if bus();

  lcd_write_arbiter #(.FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // cyc counts posedges. A transfer is described by the edge that closes
  // its strobe cycle (m_stb_at) and whether the LCD has dropped ready yet.
  int         cyc = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [1:0] m_ovf = '0;
  logic       m_last = 1'b1, m_grant = 1'b0, m_xfer = 1'b0, m_acked = 1'b0;
  logic [7:0] m_data = '0;
  int         m_stb_at = -1;
  bit         m_armed = 0;

  always @(posedge Clock) begin
    bit f0, f1, w;
    cyc++;
    if (Reset) begin
      q0.delete(); q1.delete();
      m_ovf = '0; m_last = 1'b1; m_grant = 1'b0; m_data = '0;
      m_xfer = 1'b0; m_acked = 1'b0; m_stb_at = -1; m_armed = 1;
    end else begin
      f0 = (q0.size() == DEPTH);
      f1 = (q1.size() == DEPTH);
      if (!m_xfer) begin
        if (bus.iLCD_Ready && (q0.size() > 0 || q1.size() > 0)) begin
          if (q0.size() > 0 && q1.size() > 0) w = !m_last;
          else                                w = (q0.size() == 0);
          m_data  = w ? q1.pop_front() : q0.pop_front();
          m_grant = w; m_xfer = 1'b1; m_acked = 1'b0; m_stb_at = cyc + 1;
        end
      end else if (cyc != m_stb_at) begin
        if (!m_acked) begin
          if (!bus.iLCD_Ready)            m_acked = 1'b1;
          else if (cyc == m_stb_at + TMO) m_stb_at = cyc + 1;
        end else if (bus.iLCD_Ready) begin
          m_xfer = 1'b0; m_last = m_grant;
        end
      end
      if (bus.iReq0_Valid) begin if (f0) m_ovf[0] = 1'b1; else q0.push_back(bus.iReq0_Data); end
      if (bus.iReq1_Valid) begin if (f1) m_ovf[1] = 1'b1; else q1.push_back(bus.iReq1_Data); end
    end
  end

  // ---------------- compare ----------------
  always @(negedge Clock) begin
    if (m_armed) begin
      chk("cmp_strobe", bus.oLCD_Data_Ready, (m_xfer && m_stb_at == cyc + 1) ? 1 : 0);
      chk("cmp_busy",   bus.oBusy,     m_xfer);
      chk("cmp_grant",  bus.oGrant,    m_grant);
      chk("cmp_data",   bus.oLCD_Data, m_data);
      chk("cmp_full0",  bus.oReq0_Full, (q0.size() == DEPTH) ? 1 : 0);
      chk("cmp_full1",  bus.oReq1_Full, (q1.size() == DEPTH) ? 1 : 0);
      chk("cmp_ovf",    bus.oOverflow, m_ovf);
    end
  end

  // ---------------- LCD responder ----------------
  int         lcd_ignore = 0;
  int         lcd_low = 40;
  bit         lcd_hold = 0;
  int         low_cnt = 0;
  bit         drop_next = 0;
  logic [7:0] seen[$];
  int         stb_cyc[$];

  always @(negedge Clock) begin
    if (Reset) begin low_cnt = 0; drop_next = 0; end
    if (drop_next) begin drop_next = 0; low_cnt = lcd_low; end
    else if (low_cnt > 0) low_cnt--;
    if (bus.oLCD_Data_Ready === 1'b1 && !Reset) begin
      stb_cyc.push_back(cyc);
      if (lcd_ignore > 0) lcd_ignore--;
      else begin seen.push_back(bus.oLCD_Data); drop_next = 1; end
    end
    bus.iLCD_Ready = !(lcd_hold || low_cnt > 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input int n, input logic [7:0] d, output int edge_n);
    @(negedge Clock);
    if (n == 0) begin bus.iReq0_Valid = 1'b1; bus.iReq0_Data = d; end
    else        begin bus.iReq1_Valid = 1'b1; bus.iReq1_Data = d; end
    edge_n = cyc + 1;
    @(negedge Clock);
    bus.iReq0_Valid = 1'b0;
    bus.iReq1_Valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clock); Reset = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    seen.delete(); stb_cyc.delete();
    lcd_ignore = 0; lcd_hold = 0;
  endtask

  task automatic drain(input string nm, input int budget);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || bus.oBusy !== 1'b0) && k < budget) begin
      @(negedge Clock); k++;
    end
    vectors++;
    if (k >= budget) begin
      miscompares++;
      $display("FAIL %s: still busy after %0d cycles, required idle", nm, k);
    end
  endtask

  initial begin
    int e, n0, k;
    bus.iReq0_Valid = 1'b0; bus.iReq0_Data = '0;
    bus.iReq1_Valid = 1'b0; bus.iReq1_Data = '0;
    bus.iLCD_Ready  = 1'b1;

    // reset state
    do_reset();
    chk("rst_strobe", bus.oLCD_Data_Ready, 0);
    chk("rst_busy",   bus.oBusy, 0);
    chk("rst_data",   bus.oLCD_Data, 0);
    chk("rst_ovf",    bus.oOverflow, 0);

    // T1 single byte
    push(0, 8'h41, e);
    drain("t1_drain", 300);
    chk("t1_nstb",   stb_cyc.size(), 1);
    chk("t1_lat",    stb_cyc[0] - e, 1);
    chk("t1_byte",   seen[0], 8'h41);
    chk("t1_grant",  bus.oGrant, 0);
    chk("t1_hold",   bus.oLCD_Data, 8'h41);
    chk("t1_busyfall", cyc - stb_cyc[0], 42);

    // T2 round robin from a prefilled pair of FIFOs
    do_reset();
    lcd_hold = 1;
    push(0, 8'h30, e); push(0, 8'h31, e);
    push(1, 8'h50, e); push(1, 8'h51, e);
    lcd_hold = 0;
    drain("t2_drain", 600);
    chk("t2_n",  seen.size(), 4);
    chk("t2_b0", seen[0], 8'h30);
    chk("t2_b1", seen[1], 8'h50);
    chk("t2_b2", seen[2], 8'h31);
    chk("t2_b3", seen[3], 8'h51);

    // T3 overflow on req1
    do_reset();
    lcd_hold = 1;
    for (int i = 0; i < 4; i++) push(1, 8'(8'h60 + i), e);
    chk("t3_full", bus.oReq1_Full, 1);
    push(1, 8'h64, e);
    chk("t3_ovf", bus.oOverflow, 2'b10);
    lcd_hold = 0;
    drain("t3_drain", 600);
    chk("t3_n", seen.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_order", seen[i], 8'(8'h60 + i));
    chk("t3_ovf_sticky", bus.oOverflow, 2'b10);

    // T4 ack timeout -> re-strobe of the same byte
    do_reset();
    lcd_ignore = 1;
    push(0, 8'h77, e);
    drain("t4_drain", 300);
    chk("t4_nstb", stb_cyc.size(), 2);
    chk("t4_gap",  stb_cyc[1] - stb_cyc[0], TMO + 1);
    chk("t4_n",    seen.size(), 1);
    chk("t4_byte", seen[0], 8'h77);

    // T5 reset while waiting for the LCD to finish, with 3 bytes queued
    do_reset();
    push(0, 8'hA0, e);
    push(0, 8'hA1, e); push(1, 8'hA2, e); push(0, 8'hA3, e);
    chk("t5_pre_busy", bus.oBusy, 1);
    chk("t5_pre_rdy",  bus.iLCD_Ready, 0);
    @(negedge Clock); Reset = 1'b1;
    @(negedge Clock); Reset = 1'b0;
    chk("t5_strobe", bus.oLCD_Data_Ready, 0);
    chk("t5_busy",   bus.oBusy, 0);
    chk("t5_data",   bus.oLCD_Data, 0);
    chk("t5_grant",  bus.oGrant, 0);
    n0 = stb_cyc.size();
    repeat (60) @(negedge Clock);
    chk("t5_nostrobe", stb_cyc.size(), n0);

    // T6 push on the same edge IDLE pops (FIFO0 at 3 entries)
    do_reset();
    lcd_hold = 1;
    push(0, 8'hB0, e); push(0, 8'hB1, e); push(0, 8'hB2, e);
    lcd_hold = 0;
    k = 0;
    do begin @(negedge Clock); #1; k++; end while (bus.iLCD_Ready !== 1'b1 && k < 20);
    bus.iReq0_Valid = 1'b1; bus.iReq0_Data = 8'hB3;
    @(negedge Clock);
    bus.iReq0_Valid = 1'b0;
    chk("t6_notfull", bus.oReq0_Full, 0);
    push(0, 8'hB4, e);
    chk("t6_full", bus.oReq0_Full, 1);
    drain("t6_drain", 1000);
    chk("t6_n", seen.size(), 5);
    for (int i = 0; i < 5; i++) chk("t6_order", seen[i], 8'(8'hB0 + i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
